mem_region_decoder: RTL and testbench

Parametrised, registered successor to the SoC memory decoder. It maps a 32-bit CPU virtual address onto one of NREG memory regions, such as data RAM, stack, VGA and IO. Each hit produces a one-hot device enable, a bank select and a translated physical address, one cycle after the request. It sits between the ALU/EX stage address output and the data-memory / VGA / IO mux. It also keeps a sticky fault record: first bad address, cause, and a saturating fault count.

---
 rtl/mem_region_decoder.sv | 136 +++++++++++++
 tb/tb_mem_region_decoder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mem_region_decoder.sv
// Registered virtual-to-physical region decoder with sticky fault capture.
// Optional misalignment checking is compiled in with `define ALIGN_CHECK_EN.
module mem_region_decoder #(
    parameter int unsigned NREG    = 4,
    parameter int unsigned PADDR_W = 13,
    parameter logic [NREG*32-1:0] BASE =
        {32'hFFFF0000, 32'h0000B800, 32'h7FFFEFFC, 32'h10010000},
    parameter logic [NREG*32-1:0] LIMIT =
        {32'hFFFF000C, 32'h0000CACF, 32'h7FFFFFFB, 32'h10010FFF},
    parameter logic [NREG*PADDR_W-1:0] PBASE = {13'd0, 13'd0, 13'd4096, 13'd0},
    localparam int unsigned BW = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    input  logic               req_write,
    input  logic [31:0]        req_addr,
    input  logic [1:0]         req_size,
    input  logic               fault_clr,
    output logic               dec_valid,
    output logic               dec_write,
    output logic [PADDR_W-1:0] dec_paddr,
    output logic [NREG-1:0]    dec_enable,
    output logic [BW-1:0]      dec_bank,
    output logic               dec_fault,
    output logic               fault_sticky,
    output logic [31:0]        fault_addr,
    output logic [1:0]         fault_cause,
    output logic [7:0]         fault_count
);

    logic               hit;
    logic [BW-1:0]      hitIdx;
    logic [PADDR_W-1:0] hitPaddr;
    logic [NREG-1:0]    hitOneHot;
    logic [31:0]        offset;
    logic               misalign;
    logic               fault;
    logic [1:0]         faultCause;

    logic               stickyD;
    logic [31:0]        faultAddrD;
    logic [1:0]         faultCauseD;
    logic [7:0]         faultCountD;

    // Scan from the top down so the lowest matching index is the one left standing.
    always_comb begin
        hit       = 1'b0;
        hitIdx    = '0;
        hitPaddr  = '0;
        hitOneHot = '0;
        offset    = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (req_addr >= BASE[i*32 +: 32] && req_addr <= LIMIT[i*32 +: 32]) begin
                hit          = 1'b1;
                hitIdx       = BW'(i);
                offset       = req_addr - BASE[i*32 +: 32];
                hitPaddr     = offset[PADDR_W-1:0] + PBASE[i*PADDR_W +: PADDR_W];
                hitOneHot    = '0;
                hitOneHot[i] = 1'b1;
            end
        end
    end

`ifdef ALIGN_CHECK_EN
    always_comb begin
        misalign = 1'b0;
        if (req_size == 2'b01) begin
            misalign = req_addr[0];
        end else if (req_size[1]) begin
            misalign = (req_addr[1:0] != 2'b00);
        end
    end
`else
    logic unusedSize;
    assign unusedSize = ^req_size;
    assign misalign   = 1'b0;
`endif

    assign fault      = req_valid && (misalign || !hit);
    assign faultCause = misalign ? 2'b10 : 2'b01;

    // A coincident clear is applied first so the new fault becomes the first one.
    always_comb begin
        stickyD     = fault_clr ? 1'b0  : fault_sticky;
        faultAddrD  = fault_clr ? 32'd0 : fault_addr;
        faultCauseD = fault_clr ? 2'b00 : fault_cause;
        faultCountD = fault_clr ? 8'd0  : fault_count;
        if (fault) begin
            if (!stickyD) begin
                faultAddrD  = req_addr;
                faultCauseD = faultCause;
            end
            stickyD = 1'b1;
            if (faultCountD != 8'hFF) begin
                faultCountD = faultCountD + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_valid  <= 1'b0;
            dec_write  <= 1'b0;
            dec_paddr  <= '0;
            dec_enable <= '0;
            dec_bank   <= '0;
            dec_fault  <= 1'b0;
        end else begin
            dec_valid  <= req_valid;
            dec_write  <= req_write;
            dec_fault  <= fault;
            dec_enable <= (req_valid && !fault) ? hitOneHot : '0;
            // Idle cycles keep the last paddr/bank visible.
            if (req_valid) begin
                dec_paddr <= fault ? '0 : hitPaddr;
                dec_bank  <= fault ? '0 : hitIdx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_sticky <= 1'b0;
            fault_addr   <= '0;
            fault_cause  <= 2'b00;
            fault_count  <= '0;
        end else begin
            fault_sticky <= stickyD;
            fault_addr   <= faultAddrD;
            fault_cause  <= faultCauseD;
            fault_count  <= faultCountD;
        end
    end

endmodule

// File: tb/tb_mem_region_decoder.sv
// Directed bench for mem_region_decoder: vector table plus sticky-fault and reset sequences.
// Expected values follow the ALIGN_CHECK_EN setting of the build.
module tb_mem_region_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [1:0]  req_size = 2'd0;
    logic        fault_clr = 1'b0;
    logic        dec_valid;
    logic        dec_write;
    logic [12:0] dec_paddr;
    logic [3:0]  dec_enable;
    logic [1:0]  dec_bank;
    logic        dec_fault;
    logic        fault_sticky;
    logic [31:0] fault_addr;
    logic [1:0]  fault_cause;
    logic [7:0]  fault_count;

    int total = 0;
    int bad   = 0;

    mem_region_decoder dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .fault_clr    (fault_clr),
        .dec_valid    (dec_valid),
        .dec_write    (dec_write),
        .dec_paddr    (dec_paddr),
        .dec_enable   (dec_enable),
        .dec_bank     (dec_bank),
        .dec_fault    (dec_fault),
        .fault_sticky (fault_sticky),
        .fault_addr   (fault_addr),
        .fault_cause  (fault_cause),
        .fault_count  (fault_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic        write;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  en;
        logic [1:0]  bank;
        logic [12:0] paddr;
        logic        fault;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chkAllZero(input string tag);
        chk({tag, " dec_valid"}, 32'(dec_valid), 32'd0);
        chk({tag, " dec_write"}, 32'(dec_write), 32'd0);
        chk({tag, " dec_paddr"}, 32'(dec_paddr), 32'd0);
        chk({tag, " dec_enable"}, 32'(dec_enable), 32'd0);
        chk({tag, " dec_bank"}, 32'(dec_bank), 32'd0);
        chk({tag, " dec_fault"}, 32'(dec_fault), 32'd0);
        chk({tag, " fault_sticky"}, 32'(fault_sticky), 32'd0);
        chk({tag, " fault_addr"}, fault_addr, 32'd0);
        chk({tag, " fault_cause"}, 32'(fault_cause), 32'd0);
        chk({tag, " fault_count"}, 32'(fault_count), 32'd0);
    endtask

    task automatic drive(input logic v, input logic w, input logic [31:0] a,
                         input logic [1:0] s, input logic c);
        @(negedge clk);
        req_valid = v;
        req_write = w;
        req_addr  = a;
        req_size  = s;
        fault_clr = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Odd addresses use byte size so hits are the same with or without alignment checks.
        vecs[0]  = '{1'b1, 1'b0, 32'h10010004, 2'd2, 4'b0001, 2'd0, 13'h0004, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 32'h7FFFFFFB, 2'd0, 4'b0010, 2'd1, 13'h1FFF, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 32'h7FFFEFFC, 2'd2, 4'b0010, 2'd1, 13'h1000, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 32'h0000CACF, 2'd0, 4'b0100, 2'd2, 13'h12CF, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 32'h00000000, 2'd0, 4'b0000, 2'd2, 13'h12CF, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 32'h0000CAD0, 2'd2, 4'b0000, 2'd0, 13'h0000, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 32'hFFFF0000, 2'd2, 4'b1000, 2'd3, 13'h0000, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 32'hFFFF000C, 2'd2, 4'b1000, 2'd3, 13'h000C, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 32'hFFFF000D, 2'd0, 4'b0000, 2'd0, 13'h0000, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 32'h1000FFFF, 2'd0, 4'b0000, 2'd0, 13'h0000, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 32'h10010FFF, 2'd0, 4'b0001, 2'd0, 13'h0FFF, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 32'h0000B7FF, 2'd0, 4'b0000, 2'd0, 13'h0000, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 32'h0000B800, 2'd0, 4'b0100, 2'd2, 13'h0000, 1'b0};
`ifdef ALIGN_CHECK_EN
        vecs[13] = '{1'b1, 1'b0, 32'hFFFF0001, 2'd1, 4'b0000, 2'd0, 13'h0000, 1'b1};
        vecs[14] = '{1'b1, 1'b0, 32'hFFFF0002, 2'd2, 4'b0000, 2'd0, 13'h0000, 1'b1};
`else
        vecs[13] = '{1'b1, 1'b0, 32'hFFFF0001, 2'd1, 4'b1000, 2'd3, 13'h0001, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 32'hFFFF0002, 2'd2, 4'b1000, 2'd3, 13'h0002, 1'b0};
`endif
        vecs[15] = '{1'b1, 1'b0, 32'h7FFFEFFB, 2'd0, 4'b0000, 2'd0, 13'h0000, 1'b1};

        #2 rst = 1'b1;
        #1 chkAllZero("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].valid, vecs[i].write, vecs[i].addr, vecs[i].size, 1'b0);
            chk($sformatf("v%0d dec_valid", i), 32'(dec_valid), 32'(vecs[i].valid));
            chk($sformatf("v%0d dec_write", i), 32'(dec_write), 32'(vecs[i].write));
            chk($sformatf("v%0d dec_enable", i), 32'(dec_enable), 32'(vecs[i].en));
            chk($sformatf("v%0d dec_bank", i), 32'(dec_bank), 32'(vecs[i].bank));
            chk($sformatf("v%0d dec_paddr", i), 32'(dec_paddr), 32'(vecs[i].paddr));
            chk($sformatf("v%0d dec_fault", i), 32'(dec_fault), 32'(vecs[i].fault));
        end

        // Clear with no request: sticky state returns to zero.
        drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b1);
        chk("clr sticky", 32'(fault_sticky), 32'd0);
        chk("clr count", 32'(fault_count), 32'd0);
        chk("clr addr", fault_addr, 32'd0);
        chk("clr cause", 32'(fault_cause), 32'd0);

        // First fault wins; later fault only counts.
        drive(1'b1, 1'b0, 32'h00000000, 2'd2, 1'b0);
        drive(1'b1, 1'b0, 32'h20000000, 2'd2, 1'b0);
        chk("two faults sticky", 32'(fault_sticky), 32'd1);
        chk("two faults addr", fault_addr, 32'h00000000);
        chk("two faults cause", 32'(fault_cause), 32'd1);
        chk("two faults count", 32'(fault_count), 32'd2);

        // Clear coincident with a fault captures the new fault.
        drive(1'b1, 1'b0, 32'hFFFF0010, 2'd2, 1'b1);
        chk("clr+fault sticky", 32'(fault_sticky), 32'd1);
        chk("clr+fault count", 32'(fault_count), 32'd1);
        chk("clr+fault addr", fault_addr, 32'hFFFF0010);
        chk("clr+fault cause", 32'(fault_cause), 32'd1);
        chk("clr+fault dec_fault", 32'(dec_fault), 32'd1);

`ifdef ALIGN_CHECK_EN
        drive(1'b1, 1'b0, 32'hFFFF0001, 2'd1, 1'b1);
        chk("misalign cause", 32'(fault_cause), 32'd2);
        chk("misalign addr", fault_addr, 32'hFFFF0001);
        chk("misalign enable", 32'(dec_enable), 32'd0);
`endif

        // Saturation over 300 back-to-back faults.
        drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b1);
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 1'b1, 32'h20000000, 2'd2, 1'b0);
            if (i == 253) chk("count at 254", 32'(fault_count), 32'd254);
        end
        chk("count saturated", 32'(fault_count), 32'd255);
        chk("burst sticky", 32'(fault_sticky), 32'd1);
        chk("burst dec_fault", 32'(dec_fault), 32'd1);
        chk("burst dec_write", 32'(dec_write), 32'd1);

        // Reset asserted mid-burst clears everything without waiting for an edge.
        @(negedge clk);
        rst = 1'b1;
        #1 chkAllZero("async reset");
        @(negedge clk);
        rst       = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        @(posedge clk);
        #1;
        chk("post reset dec_valid", 32'(dec_valid), 32'd0);
        chk("post reset dec_fault", 32'(dec_fault), 32'd0);
        chk("post reset count", 32'(fault_count), 32'd0);
        chk("post reset sticky", 32'(fault_sticky), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
